// File: rtl/csb_seq.sv
// csb_seq: command sequencer that fetches fixed-length layer commands from a FWFT FIFO,
// decodes them and dispatches each to one of NUM_ENG engines under a per-command watchdog.
module csb_seq #(
    parameter int CMD_W     = 32,
    parameter int CMD_WORDS = 6,
    parameter int NUM_ENG   = 3,
    parameter int CNT_W     = 7,
    parameter int TIMEOUT_W = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 op_en,
    input  logic                 op_abort,
    input  logic                 irq_clr,
    input  logic [CNT_W-1:0]     cmd_size,
    input  logic [CMD_W-1:0]     cmd,
    input  logic                 cmd_fifo_empty,
    output logic                 cmd_fifo_rd_en,
    output logic [NUM_ENG-1:0]   eng_ready,
    input  logic [NUM_ENG-1:0]   eng_valid,
    output logic [2:0]           op_type,
    output logic                 padding,
    output logic [7:0]           stride_1,
    output logic [15:0]          stride_2,
    output logic [15:0]          ich_size,
    output logic [15:0]          och_size,
    output logic [15:0]          ikn_size,
    output logic [15:0]          okn_size,
    output logic [31:0]          weight_addr,
    output logic [31:0]          data_addr,
    output logic [31:0]          wb_addr,
    output logic                 p0_reads_en,
    output logic                 p1_reads_en,
    output logic [CNT_W-1:0]     cmd_done_cnt,
    output logic                 busy,
    output logic                 irq,
    output logic                 err
);

    localparam int IDX_W = $clog2(CMD_WORDS);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(CMD_WORDS - 1);
    localparam logic [NUM_ENG-1:0] ENG_ONE  = NUM_ENG'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     word_idx;
    logic [CNT_W-1:0]     size_r;
    logic [CNT_W-1:0]     cnt_inc;
    logic [TIMEOUT_W-1:0] wdog;
    logic [TIMEOUT_W-1:0] wdog_inc;
    logic [2:0]           eng_sel;
    logic                 op_legal;
    logic [NUM_ENG-1:0]   eng_onehot;
    logic                 sel_valid;
    logic                 wdog_expired;
    logic                 err_set;
    logic                 irq_set;
    logic                 start;

    // Engine decode: op_type 1..3 share engine 0, higher codes map one-to-one from engine 1.
    always_comb begin
        eng_sel  = 3'd0;
        op_legal = 1'b0;
        if (op_type >= 3'd4) begin
            eng_sel  = op_type - 3'd3;
            op_legal = (int'(eng_sel) < NUM_ENG);
        end else if (op_type != 3'd0) begin
            eng_sel  = 3'd0;
            op_legal = 1'b1;
        end
    end

    assign eng_onehot   = ENG_ONE << eng_sel;
    assign sel_valid    = |(eng_valid & eng_onehot);
    assign cnt_inc      = cmd_done_cnt + 1'b1;
    assign wdog_inc     = wdog + 1'b1;
    assign wdog_expired = &wdog_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cmd_fifo_rd_en = 1'b0;
        busy           = 1'b0;
        case (state)
            S_IDLE: begin
                if (op_en) begin
                    state_nxt = (cmd_size == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                busy           = 1'b1;
                cmd_fifo_rd_en = !cmd_fifo_empty;
                if (!cmd_fifo_empty && (word_idx == LAST_IDX)) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy      = 1'b1;
                state_nxt = op_legal ? S_WAIT : S_ERROR;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (sel_valid) begin
                    state_nxt = (cnt_inc == size_r) ? S_DONE : S_COLLECT;
                end else if (wdog_expired) begin
                    state_nxt = S_ERROR;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERROR: begin
                if (irq_clr) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // Abort overrides every other transition.
        if (op_abort) begin
            state_nxt = S_IDLE;
        end
    end

    assign start   = (state == S_IDLE) && op_en && !op_abort;
    assign err_set = (state_nxt == S_ERROR) && (state != S_ERROR);
    assign irq_set = err_set || ((state == S_DONE) && !op_abort);

    // Word index and field capture; fields hold until the next command's word 0 lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx    <= '0;
            op_type     <= '0;
            padding     <= 1'b0;
            stride_1    <= '0;
            stride_2    <= '0;
            ich_size    <= '0;
            och_size    <= '0;
            ikn_size    <= '0;
            okn_size    <= '0;
            weight_addr <= '0;
            data_addr   <= '0;
            wb_addr     <= '0;
        end else begin
            if (cmd_fifo_rd_en) begin
                word_idx <= (word_idx == LAST_IDX) ? '0 : word_idx + 1'b1;
                case (int'(word_idx))
                    0: begin
                        op_type  <= cmd[2:0];
                        padding  <= cmd[3];
                        stride_1 <= cmd[15:8];
                        stride_2 <= cmd[31:16];
                    end
                    1: begin
                        ich_size <= cmd[15:0];
                        och_size <= cmd[31:16];
                    end
                    2: begin
                        ikn_size <= cmd[15:0];
                        okn_size <= cmd[31:16];
                    end
                    3:       weight_addr <= cmd[31:0];
                    4:       data_addr   <= cmd[31:0];
                    5:       wb_addr     <= cmd[31:0];
                    default: ;
                endcase
            end else if (state != S_COLLECT) begin
                word_idx <= '0;
            end
        end
    end

    // Engine start and DMA enables, plus the per-command watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_ready   <= '0;
            p0_reads_en <= 1'b0;
            p1_reads_en <= 1'b0;
            wdog        <= '0;
        end else begin
            if (op_abort || (state_nxt == S_ERROR) || ((state == S_WAIT) && sel_valid)) begin
                eng_ready   <= '0;
                p0_reads_en <= 1'b0;
                p1_reads_en <= 1'b0;
            end else if ((state == S_ISSUE) && op_legal) begin
                eng_ready   <= eng_onehot;
                p0_reads_en <= 1'b1;
                p1_reads_en <= (eng_sel == 3'd0);
            end
            if (state == S_ISSUE) begin
                wdog <= '0;
            end else if (state == S_WAIT) begin
                wdog <= wdog_inc;
            end
        end
    end

    // Run bookkeeping and sticky flags; a set beats a clear on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_r       <= '0;
            cmd_done_cnt <= '0;
            irq          <= 1'b0;
            err          <= 1'b0;
        end else begin
            if (start) begin
                size_r       <= cmd_size;
                cmd_done_cnt <= '0;
            end else if ((state == S_WAIT) && sel_valid && !op_abort) begin
                cmd_done_cnt <= cnt_inc;
            end
            if (irq_set) begin
                irq <= 1'b1;
            end else if (irq_clr) begin
                irq <= 1'b0;
            end
            if (err_set) begin
                err <= 1'b1;
            end else if (irq_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: doc/csb_seq.md
# csb_seq

Parametrised command sequencer for the accelerator's control path. It fetches fixed-length compressed layer commands from the command FIFO, decodes them into layer attributes and addresses, and dispatches each one to one of `NUM_ENG` compute engines (conv, maxpool, avepool by default) with a ready/valid handshake. It counts completed commands against a host-supplied total, watches each engine for a hang, and raises a sticky interrupt on completion or error. It replaces the fixed three-engine sequencer and sits between the command FIFO, the DMA port enables and the engine handshakes.

## Interface
- `CMD_W`, 32, command FIFO word width (field layout below requires 32)
- `CMD_WORDS`, 6, words per command (≥6; words 6..CMD_WORDS-1 consumed and ignored)
- `NUM_ENG`, 3, number of engines (1..6)
- `CNT_W`, 7, width of command count
- `TIMEOUT_W`, 24, width of engine watchdog counter

- `clk`  in  1  single clock
- `rst_n`  in  1  asynchronous, active-low reset
- `op_en`  in  1  start pulse; sampled only in IDLE
- `op_abort`  in  1  soft abort, any state
- `irq_clr`  in  1  clears `irq`/`err`; exits ERROR
- `cmd_size`  in  CNT_W  commands to execute
- `cmd`  in  CMD_W  FIFO data, first-word-fall-through
- `cmd_fifo_empty`  in  1  FIFO empty
- `cmd_fifo_rd_en`  out  1  consume current FIFO word
- `eng_ready`  out  NUM_ENG  one-hot start to selected engine
- `eng_valid`  in  NUM_ENG  engine done
- `op_type`  out  3;  `padding` out 1;  `stride_1` out 8;  `stride_2` out 16
- `ich_size`, `och_size`, `ikn_size`, `okn_size`  out  16 each
- `weight_addr`, `data_addr`, `wb_addr`  out  32 each
- `p0_reads_en`  out  1  data DMA read enable
- `p1_reads_en`  out  1  weight DMA read enable
- `cmd_done_cnt`  out  CNT_W  commands completed this run
- `busy`  out  1  state not IDLE/ERROR
- `irq`  out  1  sticky interrupt
- `err`  out  1  sticky error flag

## Operation
- States: IDLE, COLLECT, ISSUE, WAIT, DONE, ERROR.
- IDLE:
  - `op_en` with `cmd_size`≠0 → COLLECT, `cmd_done_cnt`←0.
  - `op_en` with `cmd_size`=0 → DONE.
- COLLECT:
  - `cmd_fifo_rd_en` = COLLECT && !`cmd_fifo_empty` (combinational). Each asserted cycle consumes one word, and a word index 0..CMD_WORDS-1 advances.
  - Empty FIFO stalls without losing the index.
  - Field capture: word0 `op_type`[2:0], `padding`[3], `stride_1`[15:8], `stride_2`[31:16]; word1 `ich_size`[15:0], `och_size`[31:16]; word2 `ikn_size`/`okn_size` likewise; word3 `weight_addr`; word4 `data_addr`; word5 `wb_addr`.
  - Last word consumed → ISSUE.
- Engine select: op_type 1–3 → engine 0; op_type k≥4 → engine k−3.
  - op_type 0, or a selected index ≥ NUM_ENG, is illegal.
- ISSUE (1 cycle):
  - Legal op_type → WAIT. Set `eng_ready[sel]` and `p0_reads_en`. Set `p1_reads_en` only for engine 0. Clear the watchdog.
  - Illegal op_type → ERROR.
- WAIT:
  - `eng_valid[sel]` high → clear `eng_ready`, `p0_reads_en` and `p1_reads_en`; `cmd_done_cnt`+1. If the new count equals `cmd_size` → DONE, else → COLLECT.
  - `eng_valid` on non-selected bits is ignored.
  - Watchdog increments each WAIT cycle. Reaching all-ones without valid → ERROR.
- DONE: `irq`←1, → IDLE.
- ERROR:
  - On entry: `err`←1, `irq`←1, all `eng_ready` and `pX_reads_en` cleared.
  - Stays in ERROR until `irq_clr`, then → IDLE.
- `irq_clr` clears `irq`/`err` in any state. If a set and a clear land on the same edge, the set wins.
- `op_abort`: next state IDLE from any state. Clears `eng_ready`, `pX_reads_en`. `irq`/`err` unchanged. Unconsumed FIFO words remain. Abort has priority over all other transitions.
- `op_en` outside IDLE is ignored. `cmd_size` is sampled at start and held internally for the run.

## Timing
- All outputs are registered except `cmd_fifo_rd_en` and `busy` (decoded from state).
- Reset values: state IDLE; all outputs 0, including all fields, addresses, `cmd_done_cnt`, `irq`, `err`.
- With a non-empty FIFO, `op_en` sampled at edge k:
  - words are consumed at edges k+1..k+CMD_WORDS;
  - ISSUE occupies the cycle after edge k+CMD_WORDS;
  - `eng_ready` rises at edge k+CMD_WORDS+1.
- `eng_valid` sampled at edge m: `eng_ready` low after edge m. The next command's first word is consumed at edge m+1.
- Decoded fields are stable from ISSUE until the next command's word 0 is consumed.

## Test plan
- Two commands (op_type 2 then 4), `cmd_size`=2, FIFO full:
  - `eng_ready`=001 at edge 7 with `p0_reads_en`=`p1_reads_en`=1;
  - then 010 with only `p0_reads_en`;
  - `irq`=1 after the second valid; `cmd_done_cnt`=2.
- FIFO empty for 5 cycles after word 2: `cmd_fifo_rd_en` low during the gap; all fields correct; `eng_ready` rises 5 cycles late.
- op_type 6 with NUM_ENG=3 → ERROR, `err`=`irq`=1, no `eng_ready`; `irq_clr` → IDLE with `err`=0.
- TIMEOUT_W=4 with engine never valid → ERROR 15 WAIT cycles after `eng_ready` rises; `eng_ready` dropped.
- `op_abort` mid-WAIT → IDLE next cycle, `eng_ready`=0, `irq`=0; a fresh `op_en` restarts with `cmd_done_cnt`=0.
- `cmd_size`=0 with `op_en` → `irq`=1 two edges later, `cmd_fifo_rd_en` never asserted. `irq_clr` on the same edge as DONE → `irq` remains 1.
